// File: rtl/zuse_fp_pkg.sv
// rtl/zuse_fp_pkg.sv - shared types and defaults for the tinyZuse FP add/sub unit
package zuse_fp_pkg;

    localparam int EXP_W_DEF = 7;
    localparam int MAN_W_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [MAN_W_DEF-1:0] man;
    } fp_t;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic unf;
    } flags_t;

endpackage

// File: rtl/zuse_lzc.sv
// rtl/zuse_lzc.sv - combinational leading-zero counter, returns W for all-zero input
module zuse_lzc #(
    parameter int W  = 15,
    parameter int CW = $clog2(W) + 1
) (
    input  logic [W-1:0]  data,
    output logic [CW-1:0] count
);

    // Ascending scan: the highest set bit is written last and wins.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (data[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/zuse_fp_addsub.sv
// rtl/zuse_fp_addsub.sv - handshaked multi-cycle floating-point add/subtract unit
module zuse_fp_addsub
    import zuse_fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic             a_sign,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [MAN_W-1:0] a_man,
    input  logic             b_sign,
    input  logic [EXP_W-1:0] b_exp,
    input  logic [MAN_W-1:0] b_man,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_sign,
    output logic [EXP_W-1:0] res_exp,
    output logic [MAN_W-1:0] res_man,
    output logic             flag_zero,
    output logic             flag_ovf,
    output logic             flag_unf
);

    localparam int CW = $clog2(MAN_W) + 1;
    localparam int DW = EXP_W + 1;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MIN = XW'(-(1 << (EXP_W - 1)));

    state_t               state;
    flags_t               flags;
    logic                 a_sign_r, b_sign_r, l_sign, same_sign;
    logic [EXP_W-1:0]     a_exp_r, b_exp_r, l_exp;
    logic [MAN_W-1:0]     a_man_r, b_man_r, l_man, s_man;
    logic [MAN_W:0]       sum;
    logic signed [XW-1:0] exp_work;

    logic [DW-1:0]        diff, shamt;
    logic                 a_wins;
    logic [MAN_W-1:0]     s_pre, s_shifted;

    // A zero operand always loses so the other one passes through untouched.
    always_comb begin
        diff  = {a_exp_r[EXP_W-1], a_exp_r} - {b_exp_r[EXP_W-1], b_exp_r};
        shamt = diff[DW-1] ? -diff : diff;
        if (a_man_r == '0)      a_wins = 1'b0;
        else if (b_man_r == '0) a_wins = 1'b1;
        else if (diff != '0)    a_wins = !diff[DW-1];
        else                    a_wins = (a_man_r >= b_man_r);
        s_pre     = a_wins ? b_man_r : a_man_r;
        s_shifted = (shamt >= DW'(MAN_W)) ? '0 : (s_pre >> shamt);
    end

    logic [CW-1:0]        lz;
    logic [MAN_W-1:0]     norm_man;
    logic signed [XW-1:0] norm_exp;

    zuse_lzc #(.W(MAN_W)) u_lzc (
        .data  (sum[MAN_W-1:0]),
        .count (lz)
    );

    always_comb begin
        if (sum[MAN_W]) begin
            norm_man = sum[MAN_W:1];
            norm_exp = exp_work + XW'(1);
        end else begin
            norm_man = sum[MAN_W-1:0] << lz;
            norm_exp = exp_work - XW'(lz);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res_sign  <= 1'b0;
            res_exp   <= '0;
            res_man   <= '0;
            flags     <= '0;
            a_sign_r  <= 1'b0;
            b_sign_r  <= 1'b0;
            a_exp_r   <= '0;
            b_exp_r   <= '0;
            a_man_r   <= '0;
            b_man_r   <= '0;
            l_sign    <= 1'b0;
            same_sign <= 1'b0;
            l_exp     <= '0;
            l_man     <= '0;
            s_man     <= '0;
            sum       <= '0;
            exp_work  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sign_r <= a_sign;
                        a_exp_r  <= a_exp;
                        a_man_r  <= a_man;
                        b_sign_r <= b_sign ^ op_sub;
                        b_exp_r  <= b_exp;
                        b_man_r  <= b_man;
                        flags    <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    l_sign    <= a_wins ? a_sign_r : b_sign_r;
                    l_exp     <= a_wins ? a_exp_r : b_exp_r;
                    l_man     <= a_wins ? a_man_r : b_man_r;
                    s_man     <= s_shifted;
                    same_sign <= (a_sign_r == b_sign_r);
                    state     <= ST_ADD;
                end
                ST_ADD: begin
                    // L is the larger magnitude, so the difference cannot go negative.
                    sum      <= same_sign ? ({1'b0, l_man} + {1'b0, s_man})
                                          : ({1'b0, l_man} - {1'b0, s_man});
                    exp_work <= {{2{l_exp[EXP_W-1]}}, l_exp};
                    res_sign <= l_sign;
                    state    <= ST_NORM;
                end
                ST_NORM: begin
                    if (sum == '0) begin
                        res_sign   <= 1'b0;
                        res_exp    <= '0;
                        res_man    <= '0;
                        flags.zero <= 1'b1;
                    end else if (norm_exp > EXP_MAX) begin
                        res_exp   <= EXP_MAX[EXP_W-1:0];
                        res_man   <= '1;
                        flags.ovf <= 1'b1;
                    end else if (norm_exp < EXP_MIN) begin
                        res_sign   <= 1'b0;
                        res_exp    <= '0;
                        res_man    <= '0;
                        flags.zero <= 1'b1;
                        flags.unf  <= 1'b1;
                    end else begin
                        res_exp <= norm_exp[EXP_W-1:0];
                        res_man <= norm_man;
                    end
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign flag_zero = flags.zero;
    assign flag_ovf  = flags.ovf;
    assign flag_unf  = flags.unf;

endmodule

// File: tb/tb_zuse_fp_addsub.sv
// tb/tb_zuse_fp_addsub.sv - scoreboard bench for zuse_fp_addsub
module tb_zuse_fp_addsub;
    import zuse_fp_pkg::*;

    localparam int EW = EXP_W_DEF;
    localparam int MW = MAN_W_DEF;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [MW-1:0] man;
        logic          zero;
        logic          ovf;
        logic          unf;
    } res_t;

    logic          clk, reset;
    logic          in_valid, in_ready, op_sub;
    logic          a_sign, b_sign;
    logic [EW-1:0] a_exp, b_exp;
    logic [MW-1:0] a_man, b_man;
    logic          out_valid, out_ready;
    logic          res_sign;
    logic [EW-1:0] res_exp;
    logic [MW-1:0] res_man;
    logic          flag_zero, flag_ovf, flag_unf;

    int   checks = 0;
    int   fails  = 0;
    res_t sb[$];
    bit   rand_bp = 0;
    res_t actual;

    zuse_fp_addsub #(.EXP_W(EW), .MAN_W(MW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a_sign    (a_sign),
        .a_exp     (a_exp),
        .a_man     (a_man),
        .b_sign    (b_sign),
        .b_exp     (b_exp),
        .b_man     (b_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_sign  (res_sign),
        .res_exp   (res_exp),
        .res_man   (res_man),
        .flag_zero (flag_zero),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf)
    );

    assign actual = {res_sign, res_exp, res_man, flag_zero, flag_ovf, flag_unf};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: exact magnitudes, smaller operand truncated onto the larger one's grid.
    function automatic res_t model(fp_t a, fp_t b, bit sub);
        res_t   r;
        fp_t    l, s;
        int     ea, eb, le, se, sh, e;
        longint mag, sm;
        real    va, vb;
        r = '0;
        b.sign = b.sign ^ sub;
        ea = int'($signed(a.exp));
        eb = int'($signed(b.exp));
        va = (a.man == 0) ? 0.0 : real'(a.man) * (2.0 ** ea);
        vb = (b.man == 0) ? 0.0 : real'(b.man) * (2.0 ** eb);
        if (va >= vb) begin l = a; le = ea; s = b; se = eb; end
        else          begin l = b; le = eb; s = a; se = ea; end
        sh = le - se;
        sm = (s.man == 0 || sh >= MW) ? 0 : (longint'(s.man) >> sh);
        mag = (l.sign == s.sign) ? longint'(l.man) + sm : longint'(l.man) - sm;
        if (mag == 0) begin
            r.zero = 1'b1;
            return r;
        end
        e = le;
        while (mag >= (longint'(1) << MW))       begin mag = mag >> 1; e++; end
        while (mag <  (longint'(1) << (MW - 1))) begin mag = mag << 1; e--; end
        if (e > (2 ** (EW - 1)) - 1) begin
            r.sign = l.sign;
            r.exp  = EW'((2 ** (EW - 1)) - 1);
            r.man  = '1;
            r.ovf  = 1'b1;
        end else if (e < -(2 ** (EW - 1))) begin
            r.zero = 1'b1;
            r.unf  = 1'b1;
        end else begin
            r.sign = l.sign;
            r.exp  = EW'(e);
            r.man  = MW'(mag);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        res_t expv;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_result: got %h, expected none", actual);
            end else begin
                expv = sb.pop_front();
                check("result", actual, expv);
            end
        end
    end

    task automatic issue(fp_t a, fp_t b, bit sub, bit push, res_t expv);
        int n = 0;
        while (!in_ready && n < 100) begin
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("issue_timeout", 32'(in_ready), 32'd1);
            return;
        end
        {a_sign, a_exp, a_man} = a;
        {b_sign, b_exp, b_man} = b;
        op_sub   = sub;
        in_valid = 1'b1;
        if (push) sb.push_back(expv);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic dir(bit as, int ae, int am, bit bs, int be, int bm, bit sub, logic [25:0] r);
        fp_t a, b;
        a = {as, EW'(ae), MW'(am)};
        b = {bs, EW'(be), MW'(bm)};
        issue(a, b, sub, 1'b1, res_t'(r));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    function automatic fp_t rnd_fp();
        fp_t f;
        f.sign = 1'($urandom);
        f.exp  = EW'($urandom);
        f.man  = ($urandom_range(0, 7) == 0) ? '0 : {1'b1, (MW-1)'($urandom)};
        return f;
    endfunction

    initial begin
        fp_t a, b;
        bit  sub;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_sub = 1'b0;
        {a_sign, a_exp, a_man} = '0;
        {b_sign, b_exp, b_man} = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", 32'(actual), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Latency: accepted at E0, out_valid visible only after E3.
        dir(0, 0, 'h4000, 0, 0, 'h4000, 0, {1'b0, 7'd1, 15'h4000, 3'b000});
        @(posedge clk); #1; check("lat_e1", 32'(out_valid), 32'd0);
        @(posedge clk); #1; check("lat_e2", 32'(out_valid), 32'd0);
        @(posedge clk); #1; check("lat_e3", 32'(out_valid), 32'd1);
        drain();

        dir(0, 0, 'h6000, 0, 0, 'h4000, 1, {1'b0, 7'h7F, 15'h4000, 3'b000});
        dir(0, 0, 'h4000, 0, 0, 'h6000, 1, {1'b1, 7'h7F, 15'h4000, 3'b000});
        dir(0, 5, 'h5555, 0, 5, 'h5555, 1, {1'b0, 7'd0, 15'h0000, 3'b100});
        dir(1, 3, 'h4800, 0, 9, 'h0000, 0, {1'b1, 7'd3, 15'h4800, 3'b000});
        dir(0, 0, 'h0000, 1, 5, 'h0000, 0, {1'b0, 7'd0, 15'h0000, 3'b100});
        dir(0, 20, 'h4001, 0, 0, 'h7FFF, 0, {1'b0, 7'd20, 15'h4001, 3'b000});
        dir(0, 63, 'h4000, 0, 63, 'h4000, 0, {1'b0, 7'd63, 15'h7FFF, 3'b010});
        dir(0, -64, 'h6000, 0, -64, 'h4000, 1, {1'b0, 7'd0, 15'h0000, 3'b101});
        dir(1, 0, 'h4000, 1, 0, 'h4000, 1, {1'b0, 7'd0, 15'h0000, 3'b100});
        drain();

        // Backpressure: result must hold while in_valid pulses are ignored.
        out_ready = 1'b0;
        dir(0, 2, 'h7000, 0, 1, 'h6000, 0, {1'b0, 7'd3, 15'h5000, 3'b000});
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold", 32'(actual), 32'({1'b0, 7'd3, 15'h5000, 3'b000}));
            in_valid = i[0];
            {a_sign, a_exp, a_man} = {1'b1, 7'd9, 15'h7777};
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_queue", 32'(sb.size()), 32'd0);

        // Reset while in ADD aborts the operation.
        a = {1'b0, 7'd4, 15'h4321};
        b = {1'b0, 7'd4, 15'h4000};
        issue(a, b, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_outputs", 32'(actual), 32'd0);
        dir(0, 0, 'h6000, 0, 0, 'h4000, 1, {1'b0, 7'h7F, 15'h4000, 3'b000});
        drain();

        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = rnd_fp();
            b = rnd_fp();
            if ($urandom_range(0, 1) == 1) b.exp = a.exp + EW'($urandom_range(0, 4)) - EW'(2);
            if ($urandom_range(0, 3) == 0) b.man = a.man;
            sub = 1'($urandom);
            issue(a, b, sub, 1'b1, model(a, b, sub));
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/zuse_fp_addsub.md
Name: zuse_fp_addsub

Overview:
Parametrised, handshaked floating-point add/subtract unit for the tinyZuse datapath. It is the successor to the fixed 7/15-bit add/sub FSM, with three additions:
- explicit sign handling
- full leading-zero normalisation
- overflow and underflow flags

It sits between the register file and the result writeback, and processes one operation at a time.

Parameters:
EXP_W, 7, exponent width; two's complement, range [-2^(EXP_W-1), 2^(EXP_W-1)-1]
MAN_W, 15, mantissa width; explicit leading one at bit MAN_W-1, value = man/2^(MAN_W-1) * 2^exp

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  operands/op valid
in_ready  out  1  unit can accept (high only in IDLE)
op_sub  in  1  0 = a+b, 1 = a-b
a_sign  in  1  operand A sign
a_exp  in  EXP_W  operand A exponent
a_man  in  MAN_W  operand A mantissa
b_sign  in  1  operand B sign
b_exp  in  EXP_W  operand B exponent
b_man  in  MAN_W  operand B mantissa
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
res_sign  out  1  result sign
res_exp  out  EXP_W  result exponent
res_man  out  MAN_W  result mantissa
flag_zero  out  1  result is zero
flag_ovf  out  1  exponent overflow (saturated)
flag_unf  out  1  exponent underflow (flushed to zero)

Behaviour:
- Clock and reset: clk, rising edge; reset is synchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; all res_* = 0; all flags = 0.
- Reset mid-operation: abort, return to IDLE next edge, discard the operation, out_valid=0.
- Zero encoding: a_man/b_man == 0 means zero; exponent and sign are ignored on input.
- Input requirement: nonzero inputs must have man[MAN_W-1]=1. Unnormalised nonzero inputs give undefined results, and the bench must not drive them.
- Operand capture: on edge with in_valid & in_ready, all operands and op_sub are registered. Effective b sign = b_sign ^ op_sub.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE. Each stage is one cycle, and out_valid is high in DONE.
- Latency: acceptance at edge E0 gives out_valid=1 after edge E3.
- ALIGN:
  - diff = a_exp - b_exp, computed in EXP_W+1 bits.
  - Select the larger-magnitude operand L: the greater exponent wins, ties are broken by greater mantissa, and a zero operand always loses.
  - Right-shift the smaller operand's mantissa by |diff|. Shifted-out bits are discarded (truncation); a shift >= MAN_W yields 0.
- ADD:
  - Datapath width MAN_W+1.
  - Same effective signs: sum = L.man + S.man.
  - Different effective signs: sum = L.man - S.man, which is never negative.
  - res_sign = L sign; exp_work = L.exp in EXP_W+2 bits.
- NORM:
  - If sum[MAN_W]=1: shift right 1 (LSB dropped) and exp_work += 1.
  - Else if sum != 0: left shift by lzc(sum[MAN_W-1:0]) and exp_work -= lzc.
  - Exact cancellation (sum == 0): flag_zero=1, res_man=0, res_exp=0, res_sign=0.
  - Both inputs zero: same as exact cancellation (+0).
  - One input zero: result = the other operand with its effective sign, exactly.
- Overflow: exp_work > max gives flag_ovf=1, res_exp=max, res_man = all ones, sign kept.
- Underflow: exp_work < min gives flag_unf=1 and flag_zero=1, res_man=0, res_exp=0, res_sign=0.
- DONE and backpressure: res_* and flags hold stable while out_valid & !out_ready. in_ready=0 until the result is taken. The edge with out_ready=1 returns to IDLE, and out_valid drops on that same edge.
- Throughput: no back-to-back acceptance; the minimum issue interval is 5 cycles with out_ready held at 1.
- Flags apply to the current result only; they are cleared on the next acceptance.

Decomposition:
- Package zuse_fp_pkg:
  - default EXP_W/MAN_W localparams
  - FSM state enum (IDLE, ALIGN, ADD, NORM, DONE)
  - packed struct fp_t {sign, exp, man}
  - flags struct {zero, ovf, unf}
- Sub-module zuse_lzc: combinational leading-zero counter, parametrised width MAN_W, output width $clog2(MAN_W)+1. It returns MAN_W for all-zero input.
- Alignment and normalisation shifters are inline barrel shifts; there is no separate module.

Test Plan:
1. Add equal: A=(+,0,0x4000) + B=(+,0,0x4000), op_sub=0 -> res=(+,1,0x4000). Flags 0. out_valid exactly 3 cycles after acceptance.
2. Subtract with renormalisation: A=(+,0,0x6000) - B=(+,0,0x4000) -> res=(+,-1 i.e. 0x7F,0x4000). Then A=(+,0,0x4000) - B=(+,0,0x6000) -> res=(-,0x7F,0x4000).
3. Cancellation and zero operands:
   - (+,5,0x5555)-(+,5,0x5555) -> flag_zero=1, res=(+,0,0).
   - (-,3,0x4800)+(+,9,0) -> res=(-,3,0x4800), flag_zero=0.
4. Large exponent gap: (+,20,0x4001)+(+,0,0x7FFF) -> res=(+,20,0x4001), since the shift is >= 15 and truncates to 0.
5. Range limits:
   - Overflow: (+,63,0x4000)+(+,63,0x4000) -> flag_ovf=1, res=(+,63,0x7FFF).
   - Underflow: (+,-64,0x6000)-(+,-64,0x4000) -> flag_unf=1, flag_zero=1, res=(+,0,0).
6. Handshake and reset:
   - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, and in_valid pulses are ignored.
   - Assert reset during ADD -> next cycle IDLE, out_valid=0, in_ready=1. A following operation completes correctly.
